// File: rtl/md_defs.sv
// Shared definitions for the E-stage multiply/divide sequencer.
// md_op codes, FSM states and default latencies.
package md_defs;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_calc.sv
// Combinational HI/LO next-value calculator for md ops.
// In: md_op, rs_e, rt_e, hi, lo. Out: hl_n = {hi_n, lo_n}.
module md_calc
  import md_defs::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] hl_n
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;
  logic               div_zero;

  assign prod_s = $signed({{32{rs_e[31]}}, rs_e})
                * $signed({{32{rt_e[31]}}, rt_e});
  assign prod_u = {32'd0, rs_e} * {32'd0, rt_e};

  assign div_zero = (rt_e == 32'd0);

  // Divider inputs are forced to 1 on a zero divisor so the
  // operator never sees /0; the result is discarded anyway.
  logic [31:0] dvsr;
  assign dvsr = div_zero ? 32'd1 : rt_e;

  // SV signed / and % truncate toward zero, remainder
  // follows the dividend sign.
  assign quot_s = $signed(rs_e) / $signed(dvsr);
  assign rem_s  = $signed(rs_e) % $signed(dvsr);
  assign quot_u = rs_e / dvsr;
  assign rem_u  = rs_e % dvsr;

  always_comb begin
    hl_n = {hi, lo};
    case (md_op)
      MD_MULT:  hl_n = prod_s;
      MD_MULTU: hl_n = prod_u;
      MD_DIV: begin
        if (!div_zero) hl_n = {rem_s, quot_s};
      end
      MD_DIVU: begin
        if (!div_zero) hl_n = {rem_u, quot_u};
      end
      MD_MTHI:  hl_n = {rs_e, lo};
      MD_MTLO:  hl_n = {hi, rs_e};
      default:  hl_n = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle mult/div sequencer with HI/LO and D-stage stall.
// Ports: clk, reset, start, md_op, rs_e, rt_e, md_use_d -> busy, hi, lo, md_stall.
module md_sequencer
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  input  logic        md_use_d,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  md_state_e   state;
  logic [3:0]  cnt;
  logic [31:0] hi_p;
  logic [31:0] lo_p;
  logic [63:0] hl_n;

  md_calc u_calc (
    .md_op (md_op),
    .rs_e  (rs_e),
    .rt_e  (rt_e),
    .hi    (hi),
    .lo    (lo),
    .hl_n  (hl_n)
  );

  assign md_stall = md_use_d & (start | busy);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      hi_p  <= '0;
      lo_p  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            case (md_op)
              MD_MULT, MD_MULTU: begin
                hi_p  <= hl_n[63:32];
                lo_p  <= hl_n[31:0];
                cnt   <= MULT_CNT;
                busy  <= 1'b1;
                state <= ST_RUN;
              end
              MD_DIV, MD_DIVU: begin
                hi_p  <= hl_n[63:32];
                lo_p  <= hl_n[31:0];
                cnt   <= DIV_CNT;
                busy  <= 1'b1;
                state <= ST_RUN;
              end
              MD_MTHI, MD_MTLO: begin
                hi <= hl_n[63:32];
                lo <= hl_n[31:0];
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // start here is ignored; the stall rule keeps it away.
          if (cnt == 4'd1) begin
            hi    <= hi_p;
            lo    <= lo_p;
            cnt   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
